// File: rtl/nios_ii_system_cpu_oci_pkg.sv
// Shared types and sizes for the OCI direct-compressed-trace path.
// Optional macro NIOS_OCI_DCT_TIMESTAMP_EN adds a 16-bit timestamp to each frame.
package nios_ii_system_cpu_oci_pkg;

  localparam int CODE_W    = 2;
  localparam int MAX_CODES = 15;
  localparam int DCT_BUF_W = CODE_W * MAX_CODES;
  localparam int DCT_CNT_W = 4;
  localparam int TS_W      = 16;

  typedef enum logic [1:0] {
    DCT_EMPTY,
    DCT_ACCUM,
    DCT_STALL
  } dct_state_e;

  typedef struct packed {
    logic [DCT_CNT_W-1:0] count;
    logic [DCT_BUF_W-1:0] buffer;
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    logic [TS_W-1:0]      timestamp;
`endif
  } dct_frame_t;

endpackage

// File: rtl/nios_ii_system_cpu_oci_dct_packer_if.sv
// Code-in / frame-out handshake bundle of the DCT packer.
// frame_timestamp exists only when NIOS_OCI_DCT_TIMESTAMP_EN is defined.
interface nios_ii_system_cpu_oci_dct_packer_if;
  import nios_ii_system_cpu_oci_pkg::*;

  logic                 code_valid;
  logic [CODE_W-1:0]    code;
  logic                 code_ready;
  logic                 flush_req;
  logic                 flush_ack;
  logic [DCT_BUF_W-1:0] dct_buffer;
  logic [DCT_CNT_W-1:0] dct_count;
  logic                 frame_valid;
  logic                 frame_ready;
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0]      frame_timestamp;
`endif

  modport master (
    output code_valid, code, flush_req, frame_ready,
    input  code_ready, flush_ack, dct_buffer, dct_count, frame_valid
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    , input frame_timestamp
`endif
  );

  modport slave (
    input  code_valid, code, flush_req, frame_ready,
    output code_ready, flush_ack, dct_buffer, dct_count, frame_valid
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    , output frame_timestamp
`endif
  );
endinterface

// File: rtl/nios_ii_system_cpu_oci_dct_frame_reg.sv
// One-entry valid/ready holding register for a packed DCT frame.
// A load on the same edge as a consumer take replaces the frame (full throughput).
module nios_ii_system_cpu_oci_dct_frame_reg
  import nios_ii_system_cpu_oci_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       load,
  input  dct_frame_t load_frame,
  input  logic       out_ready,
  output logic       out_valid,
  output dct_frame_t out_frame
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_frame <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_frame <= load_frame;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/nios_ii_system_cpu_oci_dct_packer.sv
// DCT packer: shifts 2-bit trace codes into an accumulator and emits full or flushed frames.
// Optional macro NIOS_OCI_DCT_TIMESTAMP_EN stamps each frame with a free-running cycle count.
module nios_ii_system_cpu_oci_dct_packer
  import nios_ii_system_cpu_oci_pkg::*;
(
  input  logic                                clk,
  input  logic                                reset_n,
  nios_ii_system_cpu_oci_dct_packer_if.slave  bus
);

  localparam int ACC_W = DCT_BUF_W - CODE_W;
  localparam logic [DCT_CNT_W-1:0] LAST_CNT = DCT_CNT_W'(MAX_CODES - 1);

  logic [ACC_W-1:0]     acc_buf;
  logic [DCT_CNT_W-1:0] acc_cnt;
  logic                 flush_ack_q;

  logic [DCT_BUF_W-1:0] buf_next;
  logic [DCT_CNT_W-1:0] cnt_next;
  logic                 emit_ok, accept, full_emit, flush_take, flush_emit, flush_done, load;
  dct_state_e           state;
  dct_frame_t           load_frame, frame;
  logic                 frame_valid;

`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ts_cnt <= '0;
    else          ts_cnt <= ts_cnt + 1'b1;
  end

  assign bus.frame_timestamp = frame.timestamp;
`endif

  // The 15th code always completes a frame, so it can only be taken when the frame slot frees up.
  always_comb begin
    emit_ok = !frame_valid || bus.frame_ready;
    state   = DCT_ACCUM;
    if (acc_cnt == '0)                       state = DCT_EMPTY;
    else if (acc_cnt == LAST_CNT && !emit_ok) state = DCT_STALL;
  end

  assign bus.code_ready = (state != DCT_STALL);
  assign accept         = bus.code_valid && bus.code_ready;

  // flush_req is held until it sees the ack, so ignore it during the ack cycle.
  always_comb begin
    buf_next   = accept ? {acc_buf, bus.code} : {{CODE_W{1'b0}}, acc_buf};
    cnt_next   = acc_cnt + DCT_CNT_W'(accept);
    full_emit  = accept && (acc_cnt == LAST_CNT);
    flush_take = bus.flush_req && !flush_ack_q;
    flush_emit = flush_take && !full_emit && (cnt_next != '0) && emit_ok;
    flush_done = flush_take && (full_emit || flush_emit || (cnt_next == '0));
    load       = full_emit || flush_emit;
    load_frame        = '0;
    load_frame.count  = cnt_next;
    load_frame.buffer = buf_next;
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    load_frame.timestamp = ts_cnt;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_buf     <= '0;
      acc_cnt     <= '0;
      flush_ack_q <= 1'b0;
    end else begin
      flush_ack_q <= flush_done;
      if (load) begin
        acc_buf <= '0;
        acc_cnt <= '0;
      end else if (accept) begin
        acc_buf <= buf_next[ACC_W-1:0];
        acc_cnt <= cnt_next;
      end
    end
  end

  nios_ii_system_cpu_oci_dct_frame_reg u_frame_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_frame (load_frame),
    .out_ready  (bus.frame_ready),
    .out_valid  (frame_valid),
    .out_frame  (frame)
  );

  assign bus.flush_ack   = flush_ack_q;
  assign bus.frame_valid = frame_valid;
  assign bus.dct_buffer  = frame.buffer;
  assign bus.dct_count   = frame.count;

endmodule

// File: tb/tb_nios_ii_system_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer: flush vector table plus full/stall/reset sequences.
module tb_nios_ii_system_cpu_oci_dct_packer;

  logic clk = 1'b0;
  logic reset_n;
  int   n_cmp = 0;
  int   n_err = 0;
  int   nframes = 0;
  int   tb_cyc = 0;

  always #5 clk = ~clk;

  nios_ii_system_cpu_oci_dct_packer_if bus();

  nios_ii_system_cpu_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always @(posedge clk) if (bus.frame_valid && bus.frame_ready) nframes <= nframes + 1;
  always @(posedge clk or negedge reset_n) if (!reset_n) tb_cyc <= 0; else tb_cyc <= tb_cyc + 1;

  typedef struct {
    int          n;
    logic [1:0]  c0, c1, c2;
    logic [29:0] exp_buf;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Offer one code and return just after the edge that accepts it.
  task automatic send(input logic [1:0] c);
    int t = 0;
    @(negedge clk);
    bus.code_valid = 1'b1;
    bus.code = c;
    while (!bus.code_ready) begin
      @(negedge clk);
      t++;
      if (t > 50) begin
        n_cmp++; n_err++;
        $display("FAIL send_timeout: code_ready still %b after %0d cycles", bus.code_ready, t);
        break;
      end
    end
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
  endtask

  // Raise flush_req and return at the sample point where flush_ack is seen.
  task automatic flush_wait(output logic got);
    int t = 0;
    got = 1'b0;
    @(negedge clk);
    bus.flush_req = 1'b1;
    while (!got && t < 50) begin
      @(posedge clk); #1;
      t++;
      got = bus.flush_ack;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL flush_timeout: flush_ack %b after %0d cycles", bus.flush_ack, t);
    end
  endtask

  task automatic release_flush();
    bus.flush_req = 1'b0;
    @(posedge clk); #1;
    chk("flush_ack_single_pulse", {31'b0, bus.flush_ack}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic got;
    int   f0;
    vecs[0] = '{3,  2'b11, 2'b10, 2'b01, 30'h00000039, 4'd3};
    vecs[1] = '{1,  2'b10, 2'b00, 2'b00, 30'h00000002, 4'd1};
    vecs[2] = '{2,  2'b01, 2'b11, 2'b00, 30'h00000007, 4'd2};
    vecs[3] = '{4,  2'b00, 2'b11, 2'b00, 30'h00000030, 4'd4};
    vecs[4] = '{5,  2'b11, 2'b11, 2'b11, 30'h000003FF, 4'd5};
    vecs[5] = '{6,  2'b10, 2'b01, 2'b11, 30'h000009E7, 4'd6};
    vecs[6] = '{14, 2'b01, 2'b10, 2'b11, 30'h06DB6DB6, 4'd14};

    reset_n = 1'b0;
    bus.code_valid = 1'b0; bus.code = 2'b00; bus.flush_req = 1'b0; bus.frame_ready = 1'b1;
    #1;
    chk("rst_code_ready",  {31'b0, bus.code_ready},  32'd1);
    chk("rst_flush_ack",   {31'b0, bus.flush_ack},   32'd0);
    chk("rst_frame_valid", {31'b0, bus.frame_valid}, 32'd0);
    chk("rst_dct_buffer",  {2'b0, bus.dct_buffer},   32'd0);
    chk("rst_dct_count",   {28'b0, bus.dct_count},   32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Full frame of 2'b01
    for (int i = 0; i < 15; i++) send(2'b01);
    chk("full01_valid",  {31'b0, bus.frame_valid}, 32'd1);
    chk("full01_buffer", {2'b0, bus.dct_buffer},   32'h15555555);
    chk("full01_count",  {28'b0, bus.dct_count},   32'd15);
    // Accumulator must be empty: flush acks with no new frame.
    flush_wait(got);
    chk("full01_acc_empty_valid", {31'b0, bus.frame_valid}, 32'd0);
    release_flush();

    // Flush vectors
    foreach (vecs[v]) begin
      for (int i = 0; i < vecs[v].n; i++)
        send((i % 3 == 0) ? vecs[v].c0 : (i % 3 == 1) ? vecs[v].c1 : vecs[v].c2);
      flush_wait(got);
      chk($sformatf("vec%0d_valid", v),  {31'b0, bus.frame_valid}, 32'd1);
      chk($sformatf("vec%0d_buffer", v), {2'b0, bus.dct_buffer},   {2'b0, vecs[v].exp_buf});
      chk($sformatf("vec%0d_count", v),  {28'b0, bus.dct_count},   {28'b0, vecs[v].exp_cnt});
      release_flush();
      chk($sformatf("vec%0d_consumed", v), {31'b0, bus.frame_valid}, 32'd0);
    end

    // Empty flush
    f0 = nframes;
    flush_wait(got);
    chk("empty_flush_valid", {31'b0, bus.frame_valid}, 32'd0);
    release_flush();
    chk("empty_flush_noframe", nframes, f0);

    // Stall: consumer blocked, 30 codes 2'b10
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b10);
    chk("stall_f1_buffer", {2'b0, bus.dct_buffer}, 32'h2AAAAAAA);
    chk("stall_f1_count",  {28'b0, bus.dct_count}, 32'd15);
    for (int i = 0; i < 14; i++) send(2'b10);
    @(negedge clk);
    bus.code_valid = 1'b1; bus.code = 2'b10;
    #1;
    chk("stall_code_ready", {31'b0, bus.code_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_hold_buffer", {2'b0, bus.dct_buffer},   32'h2AAAAAAA);
      chk("stall_hold_valid",  {31'b0, bus.frame_valid}, 32'd1);
    end
    f0 = nframes;
    bus.frame_ready = 1'b1;
    #1;
    chk("stall_resume_ready", {31'b0, bus.code_ready}, 32'd1);
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    chk("stall_f2_valid",  {31'b0, bus.frame_valid}, 32'd1);
    chk("stall_f2_buffer", {2'b0, bus.dct_buffer},   32'h2AAAAAAA);
    chk("stall_f2_count",  {28'b0, bus.dct_count},   32'd15);
    chk("stall_f1_taken",  nframes, f0 + 1);
    @(posedge clk); #1;
    chk("stall_f2_taken", nframes, f0 + 2);

    // 15th code coincides with flush_req
    for (int i = 0; i < 14; i++) send(2'b01);
    f0 = nframes;
    @(negedge clk);
    bus.code_valid = 1'b1; bus.code = 2'b01; bus.flush_req = 1'b1;
    @(posedge clk); #1;
    bus.code_valid = 1'b0;
    chk("fullflush_ack",    {31'b0, bus.flush_ack},   32'd1);
    chk("fullflush_valid",  {31'b0, bus.frame_valid}, 32'd1);
    chk("fullflush_count",  {28'b0, bus.dct_count},   32'd15);
    chk("fullflush_buffer", {2'b0, bus.dct_buffer},   32'h15555555);
    release_flush();
    chk("fullflush_no_empty_frame", {31'b0, bus.frame_valid}, 32'd0);
    chk("fullflush_one_frame", nframes, f0 + 1);

    // Reset mid-accumulation with a frame held
    bus.frame_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b01);
    for (int i = 0; i < 7; i++) send(2'b11);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_frame_valid", {31'b0, bus.frame_valid}, 32'd0);
    chk("midrst_dct_buffer",  {2'b0, bus.dct_buffer},   32'd0);
    chk("midrst_dct_count",   {28'b0, bus.dct_count},   32'd0);
    chk("midrst_code_ready",  {31'b0, bus.code_ready},  32'd1);
    chk("midrst_flush_ack",   {31'b0, bus.flush_ack},   32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    bus.frame_ready = 1'b1;
    flush_wait(got);
    chk("midrst_acc_discarded", {31'b0, bus.frame_valid}, 32'd0);
    release_flush();
    for (int i = 0; i < 15; i++) send(2'b11);
    chk("postrst_buffer", {2'b0, bus.dct_buffer}, 32'h3FFFFFFF);
`ifdef NIOS_OCI_DCT_TIMESTAMP_EN
    chk("postrst_timestamp", {16'b0, bus.frame_timestamp}, 32'(tb_cyc - 1));
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
